// File: rtl/mux_n_1_rr_reg_pkg.sv
// Shared constants for the registered N:1 round-robin multiplexer.
package mux_n_1_rr_reg_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    localparam int DEF_WIDTH    = 2;
    localparam int DEF_CHANNELS = 4;
    localparam int DEF_SEL_W    = 2;

endpackage

// File: rtl/mux_n_1_rr_reg_rr_arbiter.sv
// Combinational grant logic: fixed select or round-robin starting at ptr.
module rr_arbiter
    import mux_n_1_rr_reg_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int SEL_W    = DEF_SEL_W
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    ptr,
    input  logic                mode,
    input  logic [SEL_W-1:0]    select,
    output logic [CHANNELS-1:0] grant,
    output logic [SEL_W-1:0]    grant_idx
);

    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        if (mode == MODE_FIXED) begin
            // select values beyond the last channel match nothing, so no grant
            for (int k = 0; k < CHANNELS; k++) begin
                if (SEL_W'(k) == select && req[k]) begin
                    grant[k]  = 1'b1;
                    grant_idx = SEL_W'(k);
                end
            end
        end else begin
            // first pass covers ptr..CHANNELS-1, second pass wraps to 0..ptr-1
            for (int k = 0; k < CHANNELS; k++) begin
                if (!found && req[k] && SEL_W'(k) >= ptr) begin
                    found     = 1'b1;
                    grant[k]  = 1'b1;
                    grant_idx = SEL_W'(k);
                end
            end
            for (int k = 0; k < CHANNELS; k++) begin
                if (!found && req[k]) begin
                    found     = 1'b1;
                    grant[k]  = 1'b1;
                    grant_idx = SEL_W'(k);
                end
            end
        end
    end

endmodule

// File: rtl/mux_n_1_rr_reg.sv
// Registered N:1 mux with per-channel valid/ready and a one-entry output stage.
module mux_n_1_rr_reg
    import mux_n_1_rr_reg_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int SEL_W    = DEF_SEL_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          select,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_channel,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic [WIDTH-1:0]    out_data_q, out_data_d;
    logic [SEL_W-1:0]    out_channel_q, out_channel_d;
    logic                out_valid_q, out_valid_d;
    logic [SEL_W-1:0]    ptr_q, ptr_d;
    logic [CHANNELS-1:0] grant;
    logic [SEL_W-1:0]    grant_idx;
    logic                space;
    logic                xfer;

    rr_arbiter #(
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_arb (
        .req       (in_valid),
        .ptr       (ptr_q),
        .mode      (mode),
        .select    (select),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign space    = !out_valid_q || out_ready;
    assign in_ready = reset ? '0 : (grant & {CHANNELS{space}});
    assign xfer     = |in_ready;

    always_comb begin
        out_data_d    = out_data_q;
        out_channel_d = out_channel_q;
        out_valid_d   = out_valid_q;
        ptr_d         = ptr_q;
        if (xfer) begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (grant[k]) begin
                    out_data_d = in_data[k*WIDTH +: WIDTH];
                end
            end
            out_channel_d = grant_idx;
            out_valid_d   = 1'b1;
            if (mode == MODE_RR) begin
                ptr_d = (grant_idx == SEL_W'(CHANNELS-1)) ? '0 : grant_idx + SEL_W'(1);
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data_q    <= '0;
            out_channel_q <= '0;
            out_valid_q   <= 1'b0;
            ptr_q         <= '0;
        end else begin
            out_data_q    <= out_data_d;
            out_channel_q <= out_channel_d;
            out_valid_q   <= out_valid_d;
            ptr_q         <= ptr_d;
        end
    end

    assign out_data    = out_data_q;
    assign out_channel = out_channel_q;
    assign out_valid   = out_valid_q;

endmodule
